group_permute_stream: RTL and testbench

Streaming group-permutation engine: generalises the fixed high/low nibble swap to a parametrised data width and group size. It offers four run-time modes (pass, adjacent-pair swap, group reversal, group rotation) behind a valid/ready handshake with a 2-entry output buffer. It sits between the TinyTapeout top-level pin mapping (`ui_in`/`uo_out`/`uio_*`) and the user pins, and carries a saturating transfer counter for bring-up.

---
 rtl/group_permute_stream.sv | 139 +++++++++++++
 tb/tb_group_permute_stream.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/group_permute_stream.sv
// group_permute_stream
//
// Streaming group-permutation engine. The data word is split into
// N = DATA_W/GROUP_W groups of GROUP_W bits. Group 0 is the least
// significant group. Each accepted beat is permuted with the registered
// mode and stored in a 2-entry in-order output buffer.
//
// Modes:
//   0 pass
//   1 adjacent-pair swap (with odd N, the top group passes through)
//   2 group reversal
//   3 rotate-left by rot_q mod N groups
//
// A saturating counter tracks output handshakes.
//
// Ports:
//   clk, rst     - clock; synchronous active-high reset
//   cfg_we       - loads cfg_mode / cfg_rot into mode_q / rot_q
//   cfg_mode     - permutation mode (0..3)
//   cfg_rot      - rotate amount in groups (mode 3)
//   in_valid     - input beat valid
//   in_ready     - engine can accept a beat (registered occupancy only)
//   in_data      - input beat
//   out_valid    - output beat valid (buffer not empty)
//   out_ready    - downstream accepts the head beat
//   out_data     - head beat of the buffer (0 when empty)
//   xfer_count   - saturating count of output handshakes
module group_permute_stream #(
    parameter int DATA_W  = 8,
    parameter int GROUP_W = 4,
    parameter int CNT_W   = 8,
    localparam int N      = DATA_W / GROUP_W,
    localparam int ROT_W  = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_mode,
    input  logic [ROT_W-1:0]  cfg_rot,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  xfer_count
);

    // Build each output group by selecting its source group with a constant
    // index compare. This keeps every part-select static and maps to a
    // plain N-way mux per group.
    function automatic logic [DATA_W-1:0] permute(
        input logic [DATA_W-1:0] d,
        input logic [1:0]        mode,
        input logic [ROT_W-1:0]  rot
    );
        logic [DATA_W-1:0] res;
        int                src;
        int                r;
        res = '0;
        r   = int'(rot) % N;
        for (int g = 0; g < N; g++) begin
            case (mode)
                2'd0:    src = g;
                // With odd N, the top group has no partner and keeps its place.
                2'd1:    src = ((g ^ 1) < N) ? (g ^ 1) : g;
                2'd2:    src = N - 1 - g;
                default: src = (g - r + N) % N;
            endcase
            for (int s = 0; s < N; s++) begin
                if (s == src) begin
                    res[g*GROUP_W +: GROUP_W] = d[s*GROUP_W +: GROUP_W];
                end
            end
        end
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [1:0]        mode_q;
    logic [ROT_W-1:0]  rot_q;
    logic [1:0]        count_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [CNT_W-1:0]  xfer_q;
    logic [DATA_W-1:0] buf_q [2];
    logic              push;
    logic              pop;

    assign in_ready   = (count_q < 2'd2) && !rst;
    assign out_valid  = (count_q != 2'd0);
    assign out_data   = out_valid ? buf_q[rd_ptr_q] : '0;
    assign xfer_count = xfer_q;

    // in_ready already carries !rst, so no beat is captured during reset.
    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Control state: configuration, buffer pointers/occupancy, counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= 2'd0;
            rot_q    <= '0;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            xfer_q   <= '0;
        end else begin
            if (cfg_we) begin
                mode_q <= cfg_mode;
                rot_q  <= cfg_rot;
            end
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                xfer_q   <= sat_inc(xfer_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Data storage: the transform uses the pre-update mode_q/rot_q, so a
    // cfg_we on the same edge affects only later beats.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= permute(in_data, mode_q, rot_q);
        end
    end

endmodule

// File: tb/tb_group_permute_stream.sv
module tb_group_permute_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    // dut_a: defaults (8-bit, 4-bit groups, 8-bit counter)
    logic       a_cfg_we, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0] a_cfg_mode;
    logic [0:0] a_cfg_rot;
    logic [7:0] a_in_data, a_out_data, a_xfer_count;
    // dut_b: 16-bit, N = 4
    logic        b_cfg_we, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [1:0]  b_cfg_mode, b_cfg_rot;
    logic [15:0] b_in_data, b_out_data;
    logic [7:0]  b_xfer_count;
    // dut_c: defaults with a 2-bit counter
    logic       c_cfg_we, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [1:0] c_cfg_mode, c_xfer_count;
    logic [0:0] c_cfg_rot;
    logic [7:0] c_in_data, c_out_data;
    // dut_d: 12-bit, N = 3 (odd)
    logic        d_cfg_we, d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [1:0]  d_cfg_mode, d_cfg_rot;
    logic [11:0] d_in_data, d_out_data;
    logic [7:0]  d_xfer_count;

    group_permute_stream dut_a (
        .clk(clk), .rst(rst), .cfg_we(a_cfg_we), .cfg_mode(a_cfg_mode), .cfg_rot(a_cfg_rot),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .xfer_count(a_xfer_count));

    group_permute_stream #(.DATA_W(16), .GROUP_W(4), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .cfg_we(b_cfg_we), .cfg_mode(b_cfg_mode), .cfg_rot(b_cfg_rot),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .xfer_count(b_xfer_count));

    group_permute_stream #(.DATA_W(8), .GROUP_W(4), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .cfg_we(c_cfg_we), .cfg_mode(c_cfg_mode), .cfg_rot(c_cfg_rot),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .xfer_count(c_xfer_count));

    group_permute_stream #(.DATA_W(12), .GROUP_W(4), .CNT_W(8)) dut_d (
        .clk(clk), .rst(rst), .cfg_we(d_cfg_we), .cfg_mode(d_cfg_mode), .cfg_rot(d_cfg_rot),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
        .xfer_count(d_xfer_count));

    // Reference permutation written as whole-word shift/mask arithmetic.
    function automatic logic [31:0] ref_perm(input logic [31:0] d, input int mode,
                                             input int rot, input int dw, input int gw);
        int          n;
        int          r;
        logic [31:0] mask;
        logic [31:0] gm;
        logic [31:0] res;
        n    = dw / gw;
        mask = (32'd1 << dw) - 32'd1;
        gm   = (32'd1 << gw) - 32'd1;
        res  = '0;
        case (mode)
            0: res = d & mask;
            1: begin
                for (int g = 0; g + 1 < n; g += 2) begin
                    res |= ((d >> (g * gw)) & gm) << ((g + 1) * gw);
                    res |= ((d >> ((g + 1) * gw)) & gm) << (g * gw);
                end
                if (n % 2 == 1) res |= d & (gm << ((n - 1) * gw));
            end
            2: for (int g = 0; g < n; g++) res |= ((d >> (g * gw)) & gm) << ((n - 1 - g) * gw);
            default: begin
                r = rot % n;
                if (r == 0) res = d & mask;
                else        res = ((d << (r * gw)) | ((d & mask) >> (dw - r * gw))) & mask;
            end
        endcase
        return res;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  t_mode [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic [1:0]  t_rot  [4] = '{2'd0, 2'd0, 2'd1, 2'd0};
    logic [15:0] t_exp  [4] = '{16'h2143, 16'h4321, 16'h2341, 16'h1234};
    int          sat_exp [5] = '{1, 2, 3, 3, 3};

    logic [31:0] qb[$];
    logic [31:0] qd[$];
    int mb_mode, mb_rot, cb, md_mode, md_rot, cd;
    bit push_b, pop_b, push_d, pop_d;

    initial begin
        rst = 1'b1;
        {a_cfg_we, a_cfg_mode, a_cfg_rot, a_in_valid, a_in_data, a_out_ready} = '0;
        {b_cfg_we, b_cfg_mode, b_cfg_rot, b_in_valid, b_in_data, b_out_ready} = '0;
        {c_cfg_we, c_cfg_mode, c_cfg_rot, c_in_valid, c_in_data, c_out_ready} = '0;
        {d_cfg_we, d_cfg_mode, d_cfg_rot, d_in_valid, d_in_data, d_out_ready} = '0;
        tick;
        tick;
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_xfer", a_xfer_count, 0);
        rst = 1'b0;
        tick;
        chk("release_in_ready_a", a_in_ready, 1);
        chk("release_in_ready_b", b_in_ready, 1);

        // Default build, pair swap
        a_cfg_we = 1; a_cfg_mode = 2'd1;
        tick;
        a_cfg_we = 0; a_out_ready = 1; a_in_valid = 1; a_in_data = 8'hA5;
        tick;
        chk("swap_valid", a_out_valid, 1);
        chk("swap_a5", a_out_data, 8'h5A);
        chk("swap_xfer0", a_xfer_count, 0);
        a_in_data = 8'h3C;
        tick;
        chk("swap_3c", a_out_data, 8'hC3);
        chk("swap_xfer1", a_xfer_count, 1);
        a_in_valid = 0;
        tick;
        chk("swap_empty", a_out_valid, 0);
        chk("swap_xfer2", a_xfer_count, 2);

        // 16-bit modes on 0x1234
        for (int i = 0; i < 4; i++) begin
            b_cfg_we = 1; b_cfg_mode = t_mode[i]; b_cfg_rot = t_rot[i];
            tick;
            b_cfg_we = 0; b_out_ready = 1; b_in_valid = 1; b_in_data = 16'h1234;
            tick;
            b_in_valid = 0;
            chk($sformatf("mode16_%0d", i), b_out_data, t_exp[i]);
            tick;
            chk($sformatf("mode16_drain_%0d", i), b_out_valid, 0);
        end

        // Config write on the same edge as acceptance
        b_cfg_we = 1; b_cfg_mode = 2'd0;
        tick;
        b_cfg_mode = 2'd2; b_in_valid = 1; b_in_data = 16'h1234;
        tick;
        b_cfg_we = 0;
        chk("race_old_cfg", b_out_data, 16'h1234);
        tick;
        chk("race_new_cfg", b_out_data, 16'h4321);
        b_in_valid = 0;
        tick;
        chk("race_drain", b_out_valid, 0);

        // Backpressure
        a_cfg_we = 1; a_cfg_mode = 2'd0;
        tick;
        a_cfg_we = 0; a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h11;
        tick;
        chk("bp_ready_1", a_in_ready, 1);
        chk("bp_head_11", a_out_data, 8'h11);
        a_in_data = 8'h22;
        tick;
        chk("bp_full", a_in_ready, 0);
        a_in_data = 8'h33;
        tick;
        chk("bp_still_full", a_in_ready, 0);
        chk("bp_head_hold", a_out_data, 8'h11);
        a_out_ready = 1;
        tick;
        chk("bp_out_22", a_out_data, 8'h22);
        tick;
        chk("bp_out_33", a_out_data, 8'h33);
        a_in_valid = 0;
        tick;
        chk("bp_no_dup", a_out_valid, 0);
        chk("bp_xfer", a_xfer_count, 5);

        // Counter saturation (2-bit)
        c_out_ready = 1; c_in_valid = 1; c_in_data = 8'($urandom);
        tick;
        for (int i = 0; i < 5; i++) begin
            c_in_data = 8'($urandom);
            tick;
            chk($sformatf("sat_%0d", i), c_xfer_count, sat_exp[i]);
        end
        c_in_valid = 0;

        // Odd group count, pair swap leaves top group in place
        d_cfg_we = 1; d_cfg_mode = 2'd1;
        tick;
        d_cfg_we = 0; d_out_ready = 1; d_in_valid = 1; d_in_data = 12'hABC;
        tick;
        chk("odd_swap", d_out_data, 12'hACB);
        d_in_valid = 0;
        tick;

        // Reset mid-stream
        a_cfg_we = 1; a_cfg_mode = 2'd2;
        tick;
        a_cfg_we = 0; a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h12;
        tick;
        a_in_data = 8'h34;
        tick;
        a_in_valid = 0;
        chk("mid_full", a_in_ready, 0);
        rst = 1;
        tick;
        chk("mid_rst_valid", a_out_valid, 0);
        chk("mid_rst_data", a_out_data, 0);
        chk("mid_rst_xfer", a_xfer_count, 0);
        chk("mid_rst_ready", a_in_ready, 0);
        rst = 0;
        tick;
        chk("mid_release_ready", a_in_ready, 1);
        a_in_valid = 1; a_in_data = 8'hA5; a_out_ready = 1;
        tick;
        chk("mid_pass", a_out_data, 8'hA5);
        a_in_valid = 0;
        tick;

        // Randomized traffic on the 16-bit and odd-N builds
        rst = 1;
        tick;
        rst = 0;
        mb_mode = 0; mb_rot = 0; cb = 0;
        md_mode = 0; md_rot = 0; cd = 0;
        for (int i = 0; i < 400; i++) begin
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 3) != 0);
            b_in_data   = 16'($urandom);
            b_cfg_we    = ($urandom_range(0, 7) == 0);
            b_cfg_mode  = 2'($urandom);
            b_cfg_rot   = 2'($urandom);
            d_in_valid  = ($urandom_range(0, 3) != 0);
            d_out_ready = ($urandom_range(0, 2) != 0);
            d_in_data   = 12'($urandom);
            d_cfg_we    = ($urandom_range(0, 7) == 0);
            d_cfg_mode  = 2'($urandom);
            d_cfg_rot   = 2'($urandom);
            push_b = b_in_valid && (qb.size() < 2);
            pop_b  = b_out_ready && (qb.size() > 0);
            push_d = d_in_valid && (qd.size() < 2);
            pop_d  = d_out_ready && (qd.size() > 0);
            tick;
            if (pop_b) begin void'(qb.pop_front()); if (cb < 255) cb++; end
            if (push_b) qb.push_back(ref_perm(32'(b_in_data), mb_mode, mb_rot, 16, 4));
            if (b_cfg_we) begin mb_mode = int'(b_cfg_mode); mb_rot = int'(b_cfg_rot); end
            if (pop_d) begin void'(qd.pop_front()); if (cd < 255) cd++; end
            if (push_d) qd.push_back(ref_perm(32'(d_in_data), md_mode, md_rot, 12, 4));
            if (d_cfg_we) begin md_mode = int'(d_cfg_mode); md_rot = int'(d_cfg_rot); end
            chk("rnd_b_valid", b_out_valid, qb.size() > 0);
            chk("rnd_b_ready", b_in_ready, qb.size() < 2);
            chk("rnd_b_data", b_out_data, (qb.size() > 0) ? qb[0] : 32'd0);
            chk("rnd_b_xfer", b_xfer_count, cb);
            chk("rnd_d_valid", d_out_valid, qd.size() > 0);
            chk("rnd_d_data", d_out_data, (qd.size() > 0) ? qd[0] : 32'd0);
            chk("rnd_d_xfer", d_xfer_count, cd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
